// File: rtl/alarm_pkg.sv
// Shared widths, limits and encodings for the alarm clock user-side set controller.
package alarm_pkg;

  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned SUM_W    = MIN_W + 1;
  localparam int unsigned RING_W   = 8;
  localparam int unsigned MAX_HOUR = 23;
  localparam int unsigned MAX_MIN  = 59;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EDIT_TIME  = 2'd1,
    EDIT_ALARM = 2'd2,
    COMMIT     = 2'd3
  } edit_state_e;

  typedef enum logic {
    TGT_TIME  = 1'b0,
    TGT_ALARM = 1'b1
  } commit_tgt_e;

  typedef struct packed {
    logic mode;
    logic hour;
    logic min;
    logic set;
    logic stop;
  } btn_t;

endpackage

// File: rtl/bcd_split.sv
// Binary 0..59 to two BCD digits (tens, units); shared by the hour and minute paths.
module bcd_split
  import alarm_pkg::*;
(
  input  logic [MIN_W-1:0] bin,
  output logic [3:0]       tens_c,
  output logic [3:0]       units_c
);

  always_comb begin
    tens_c  = 4'(bin / MIN_W'(10));
    units_c = 4'(bin % MIN_W'(10));
  end

endmodule

// File: rtl/alarm_set_ctrl.sv
// Button-driven time/alarm set controller and ring supervisor for the 1 Hz alarm clock.
// Optional snooze on mode-press while ringing is built when SNOOZE_EN is defined.
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_TIMEOUT = 60
`ifdef SNOOZE_EN
  , parameter int unsigned SNOOZE_MIN = 5
`endif
) (
  input  logic       clock_1s,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_hour,
  input  logic       btn_min,
  input  logic       btn_set,
  input  logic       btn_stop,
  input  logic       alarm_en_sw,
  input  logic       Alarm,
  input  logic [1:0] cur_hour1,
  input  logic [3:0] cur_hour0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  output logic [1:0] hour_in1,
  output logic [3:0] hour_in0,
  output logic [3:0] minute_in1,
  output logic [3:0] minute_in0,
  output logic       load_time,
  output logic       load_alarm,
  output logic       STOP_alarm,
  output logic       Alarm_ON,
  output logic [1:0] edit_state
);

  edit_state_e       state_q, state_d;
  btn_t              btn_now, btn_prev_q, btn_edge;
  logic [HOUR_W-1:0] edit_hour_q, edit_hour_d, shadow_hour_q, shadow_hour_d;
  logic [MIN_W-1:0]  edit_min_q, edit_min_d, shadow_min_q, shadow_min_d;
  logic              armed_q, armed_d;
  logic              load_time_d, load_alarm_d, stop_d, dig_load;
  logic [HOUR_W-1:0] split_hour, cur_hour_bin;
  logic [MIN_W-1:0]  split_min, cur_min_bin;
  logic [3:0]        h_tens_c, h_units_c, m_tens_c, m_units_c;
  logic [RING_W-1:0] ring_cnt_q;
  logic              ring_hit;
  commit_tgt_e       tgt;

  assign btn_now  = '{mode: btn_mode, hour: btn_hour, min: btn_min, set: btn_set, stop: btn_stop};
  assign btn_edge = btn_t'(btn_now & ~btn_prev_q);

  assign cur_hour_bin = HOUR_W'(cur_hour1) * HOUR_W'(10) + HOUR_W'(cur_hour0);
  assign cur_min_bin  = MIN_W'(cur_min1) * MIN_W'(10) + MIN_W'(cur_min0);

  assign ring_hit   = Alarm && (ring_cnt_q == RING_W'(RING_TIMEOUT - 2));
  assign edit_state = state_q;

`ifdef SNOOZE_EN
  logic [SUM_W-1:0]  snz_sum;
  logic [HOUR_W-1:0] snz_hour;
  logic [MIN_W-1:0]  snz_min;
  logic              snooze_stop;

  // Current time plus snooze interval, carrying minutes into hours and wrapping at midnight.
  always_comb begin
    snz_sum  = SUM_W'(cur_min_bin) + SUM_W'(SNOOZE_MIN);
    snz_hour = cur_hour_bin;
    snz_min  = MIN_W'(snz_sum);
    if (snz_sum > SUM_W'(MAX_MIN)) begin
      snz_min  = MIN_W'(snz_sum - SUM_W'(MAX_MIN + 1));
      snz_hour = (cur_hour_bin == HOUR_W'(MAX_HOUR)) ? '0 : cur_hour_bin + HOUR_W'(1);
    end
  end
`endif

  // Edit FSM: within an edit state set outranks mode, and both outrank digit increments.
  always_comb begin
    state_d       = state_q;
    edit_hour_d   = edit_hour_q;
    edit_min_d    = edit_min_q;
    shadow_hour_d = shadow_hour_q;
    shadow_min_d  = shadow_min_q;
    armed_d       = armed_q;
    load_time_d   = 1'b0;
    load_alarm_d  = 1'b0;
    dig_load      = 1'b0;
    split_hour    = edit_hour_q;
    split_min     = edit_min_q;
    tgt           = TGT_TIME;
`ifdef SNOOZE_EN
    snooze_stop   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (btn_edge.mode) begin
`ifdef SNOOZE_EN
          if (Alarm) begin
            snooze_stop  = 1'b1;
            load_alarm_d = 1'b1;
            dig_load     = 1'b1;
            split_hour   = snz_hour;
            split_min    = snz_min;
          end else begin
            state_d     = EDIT_TIME;
            edit_hour_d = cur_hour_bin;
            edit_min_d  = cur_min_bin;
          end
`else
          state_d     = EDIT_TIME;
          edit_hour_d = cur_hour_bin;
          edit_min_d  = cur_min_bin;
`endif
        end
      end
      EDIT_TIME, EDIT_ALARM: begin
        tgt = (state_q == EDIT_TIME) ? TGT_TIME : TGT_ALARM;
        if (btn_edge.set) begin
          state_d  = COMMIT;
          dig_load = 1'b1;
          if (tgt == TGT_TIME) begin
            load_time_d = 1'b1;
          end else begin
            load_alarm_d  = 1'b1;
            shadow_hour_d = edit_hour_q;
            shadow_min_d  = edit_min_q;
            armed_d       = 1'b1;
          end
        end else if (btn_edge.mode) begin
          if (tgt == TGT_TIME) begin
            state_d     = EDIT_ALARM;
            edit_hour_d = shadow_hour_q;
            edit_min_d  = shadow_min_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (btn_edge.hour) begin
            edit_hour_d = (edit_hour_q == HOUR_W'(MAX_HOUR)) ? '0 : edit_hour_q + HOUR_W'(1);
          end
          if (btn_edge.min) begin
            edit_min_d = (edit_min_q == MIN_W'(MAX_MIN)) ? '0 : edit_min_q + MIN_W'(1);
          end
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Manual and timeout stops merge into one pulse.
  always_comb begin
    stop_d = Alarm & (btn_edge.stop | ring_hit);
`ifdef SNOOZE_EN
    stop_d = stop_d | snooze_stop;
`endif
  end

  bcd_split u_hour_split (
    .bin     (MIN_W'(split_hour)),
    .tens_c  (h_tens_c),
    .units_c (h_units_c)
  );

  bcd_split u_min_split (
    .bin     (split_min),
    .tens_c  (m_tens_c),
    .units_c (m_units_c)
  );

  always_ff @(posedge clock_1s or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      btn_prev_q    <= '0;
      edit_hour_q   <= '0;
      edit_min_q    <= '0;
      shadow_hour_q <= '0;
      shadow_min_q  <= '0;
      armed_q       <= 1'b0;
      ring_cnt_q    <= '0;
      load_time     <= 1'b0;
      load_alarm    <= 1'b0;
      STOP_alarm    <= 1'b0;
      Alarm_ON      <= 1'b0;
      hour_in1      <= '0;
      hour_in0      <= '0;
      minute_in1    <= '0;
      minute_in0    <= '0;
    end else begin
      state_q       <= state_d;
      btn_prev_q    <= btn_now;
      edit_hour_q   <= edit_hour_d;
      edit_min_q    <= edit_min_d;
      shadow_hour_q <= shadow_hour_d;
      shadow_min_q  <= shadow_min_d;
      armed_q       <= armed_d;
      load_time     <= load_time_d;
      load_alarm    <= load_alarm_d;
      STOP_alarm    <= stop_d;
      Alarm_ON      <= armed_q & alarm_en_sw;
      if (!Alarm) begin
        ring_cnt_q <= '0;
      end else if (ring_cnt_q != RING_W'(RING_TIMEOUT)) begin
        ring_cnt_q <= ring_cnt_q + RING_W'(1);
      end
      if (dig_load) begin
        hour_in1   <= 2'(h_tens_c);
        hour_in0   <= h_units_c;
        minute_in1 <= m_tens_c;
        minute_in0 <= m_units_c;
      end
    end
  end

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Scoreboard bench for alarm_set_ctrl: directed scenarios then random buttons, checked against a time-arithmetic model.
module tb_alarm_set_ctrl;

  localparam int RT     = 60;
  localparam int SNOOZE = 5;
  localparam int B_MODE = 4, B_HOUR = 3, B_MIN = 2, B_SET = 1, B_STOP = 0;

  logic       clock_1s = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btns = '0;
  logic       alarm_en_sw = 1'b0;
  logic       Alarm = 1'b0;
  logic [1:0] cur_hour1 = '0;
  logic [3:0] cur_hour0 = '0, cur_min1 = '0, cur_min0 = '0;
  logic [1:0] hour_in1;
  logic [3:0] hour_in0, minute_in1, minute_in0;
  logic       load_time, load_alarm, STOP_alarm, Alarm_ON;
  logic [1:0] edit_state;

  always #5 clock_1s = ~clock_1s;

  alarm_set_ctrl dut (
    .clock_1s    (clock_1s),
    .reset       (reset),
    .btn_mode    (btns[B_MODE]),
    .btn_hour    (btns[B_HOUR]),
    .btn_min     (btns[B_MIN]),
    .btn_set     (btns[B_SET]),
    .btn_stop    (btns[B_STOP]),
    .alarm_en_sw (alarm_en_sw),
    .Alarm       (Alarm),
    .cur_hour1   (cur_hour1),
    .cur_hour0   (cur_hour0),
    .cur_min1    (cur_min1),
    .cur_min0    (cur_min0),
    .hour_in1    (hour_in1),
    .hour_in0    (hour_in0),
    .minute_in1  (minute_in1),
    .minute_in0  (minute_in0),
    .load_time   (load_time),
    .load_alarm  (load_alarm),
    .STOP_alarm  (STOP_alarm),
    .Alarm_ON    (Alarm_ON),
    .edit_state  (edit_state)
  );

  typedef struct packed {
    logic [1:0] es;
    logic       lt, la, stop, on;
    logic [1:0] h1;
    logic [3:0] h0, m1, m0;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp, mon_got;
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode number, edit/shadow times in minutes-and-hours, count of ringing seconds.
  int   m_mode, e_h, e_m, sh_h, sh_m, ring_run, out_h, out_m;
  bit   armed, o_lt, o_la, o_stop, o_on;
  logic [4:0] m_prev;

  task automatic mdl_reset();
    m_mode = 0; e_h = 0; e_m = 0; sh_h = 0; sh_m = 0; ring_run = 0;
    out_h = 0; out_m = 0; armed = 0; o_lt = 0; o_la = 0; o_stop = 0; o_on = 0;
    m_prev = '0;
  endtask

  task automatic mdl_step();
    logic [4:0] edg;
    int cur_h, cur_m, t;
    bit snooze;
    edg    = btns & ~m_prev;
    m_prev = btns;
    cur_h  = int'(cur_hour1) * 10 + int'(cur_hour0);
    cur_m  = int'(cur_min1) * 10 + int'(cur_min0);
    o_lt = 0; o_la = 0; o_stop = 0;
    o_on = armed && alarm_en_sw;
    if (Alarm) begin
      if (ring_run < RT) ring_run++;
      if (edg[B_STOP] || ring_run == RT - 1) o_stop = 1;
    end else begin
      ring_run = 0;
    end
    case (m_mode)
      0: if (edg[B_MODE]) begin
        snooze = 0;
`ifdef SNOOZE_EN
        snooze = Alarm;
`endif
        if (snooze) begin
          t = (cur_h * 60 + cur_m + SNOOZE) % 1440;
          out_h = t / 60; out_m = t % 60; o_la = 1; o_stop = 1;
        end else begin
          m_mode = 1; e_h = cur_h; e_m = cur_m;
        end
      end
      1, 2: begin
        if (edg[B_SET]) begin
          out_h = e_h; out_m = e_m;
          if (m_mode == 1) o_lt = 1;
          else begin o_la = 1; sh_h = e_h; sh_m = e_m; armed = 1; end
          m_mode = 3;
        end else if (edg[B_MODE]) begin
          if (m_mode == 1) begin m_mode = 2; e_h = sh_h; e_m = sh_m; end
          else m_mode = 0;
        end else begin
          if (edg[B_HOUR]) e_h = (e_h + 1) % 24;
          if (edg[B_MIN]) e_m = (e_m + 1) % 60;
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  function automatic obs_t mdl_obs();
    obs_t o;
    o.es = 2'(m_mode); o.lt = o_lt; o.la = o_la; o.stop = o_stop; o.on = o_on;
    o.h1 = 2'(out_h / 10); o.h0 = 4'(out_h % 10);
    o.m1 = 4'(out_m / 10); o.m0 = 4'(out_m % 10);
    return o;
  endfunction

  always @(posedge clock_1s or posedge reset) begin
    if (reset) begin
      mdl_reset();
      exp_q.delete();
    end else begin
      mdl_step();
      exp_q.push_back(mdl_obs());
    end
  end

  // Monitor: every cycle's registered outputs are compared with the queued prediction.
  always @(negedge clock_1s) begin
    if (!reset && exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {edit_state, load_time, load_alarm, STOP_alarm, Alarm_ON,
                 hour_in1, hour_in0, minute_in1, minute_in0};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL scoreboard t=%0t got %h exp %h", $time, mon_got, mon_exp);
      end
    end
  end

  task automatic dchk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  function automatic int digits();
    return int'(hour_in1) * 1000 + int'(hour_in0) * 100 + int'(minute_in1) * 10 + int'(minute_in0);
  endfunction

  function automatic int all_outs();
    return int'({edit_state, load_time, load_alarm, STOP_alarm, Alarm_ON,
                 hour_in1, hour_in0, minute_in1, minute_in0});
  endfunction

  task automatic set_cur(input int h, input int m);
    cur_hour1 = 2'(h / 10); cur_hour0 = 4'(h % 10);
    cur_min1  = 4'(m / 10); cur_min0  = 4'(m % 10);
  endtask

  task automatic press(input int idx);
    btns[idx] = 1'b1;
    @(negedge clock_1s);
    btns[idx] = 1'b0;
    @(negedge clock_1s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_stop, stop_at, alarm_left;
    mdl_reset();
    repeat (2) @(negedge clock_1s);
    dchk("reset_state", int'(edit_state), 0);
    dchk("reset_pulses", int'({load_time, load_alarm, STOP_alarm, Alarm_ON}), 0);
    dchk("reset_digits", digits(), 0);
    reset = 1'b0;
    alarm_en_sw = 1'b1;
    set_cur(12, 34);

    // Time commit from 12:34
    press(B_MODE);
    dchk("edit_time_state", int'(edit_state), 1);
    btns[B_SET] = 1'b1;
    @(negedge clock_1s);
    dchk("commit_time_lt", int'(load_time), 1);
    dchk("commit_time_digits", digits(), 1234);
    dchk("commit_state", int'(edit_state), 3);
    btns[B_SET] = 1'b0;
    @(negedge clock_1s);
    dchk("commit_time_lt_end", int'(load_time), 0);
    dchk("back_idle", int'(edit_state), 0);

    // Alarm edit from 00:00: 7 hour presses, 61 minute presses
    press(B_MODE);
    press(B_MODE);
    dchk("edit_alarm_state", int'(edit_state), 2);
    repeat (7) press(B_HOUR);
    repeat (61) press(B_MIN);
    btns[B_SET] = 1'b1;
    @(negedge clock_1s);
    dchk("commit_alarm_la", int'(load_alarm), 1);
    dchk("commit_alarm_digits", digits(), 701);
    dchk("alarm_on_not_yet", int'(Alarm_ON), 0);
    btns[B_SET] = 1'b0;
    @(negedge clock_1s);
    dchk("commit_alarm_la_end", int'(load_alarm), 0);
    dchk("alarm_on", int'(Alarm_ON), 1);

    // Simultaneous hour+minute wrap from 23:59
    set_cur(23, 59);
    press(B_MODE);
    btns[B_HOUR] = 1'b1; btns[B_MIN] = 1'b1;
    @(negedge clock_1s);
    btns[B_HOUR] = 1'b0; btns[B_MIN] = 1'b0;
    @(negedge clock_1s);
    btns[B_SET] = 1'b1;
    @(negedge clock_1s);
    dchk("wrap_lt", int'(load_time), 1);
    dchk("wrap_digits", digits(), 0);
    btns[B_SET] = 1'b0;
    @(negedge clock_1s);

    // Ring timeout: one auto stop while Alarm stays high
    Alarm = 1'b1; n_stop = 0; stop_at = -1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clock_1s);
      if (STOP_alarm) begin n_stop++; stop_at = i; end
    end
    dchk("timeout_pulses", n_stop, 1);
    dchk("timeout_cycle", stop_at, RT - 2);
    Alarm = 1'b0;
    repeat (2) @(negedge clock_1s);

    // Held stop while ringing, then stop while quiet
    Alarm = 1'b1; btns[B_STOP] = 1'b1; n_stop = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock_1s);
      if (i == 2) btns[B_STOP] = 1'b0;
      if (STOP_alarm) n_stop++;
    end
    dchk("held_stop_pulses", n_stop, 1);
    Alarm = 1'b0;
    repeat (2) @(negedge clock_1s);
    btns[B_STOP] = 1'b1; n_stop = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_1s);
      if (i == 1) btns[B_STOP] = 1'b0;
      if (STOP_alarm) n_stop++;
    end
    dchk("quiet_stop_pulses", n_stop, 0);

    // Mode press while ringing at 23:57
    set_cur(23, 57);
    Alarm = 1'b1;
    btns[B_MODE] = 1'b1;
    @(negedge clock_1s);
`ifdef SNOOZE_EN
    dchk("snooze_stop", int'(STOP_alarm), 1);
    dchk("snooze_la", int'(load_alarm), 1);
    dchk("snooze_digits", digits(), 2);
    dchk("snooze_state", int'(edit_state), 0);
`else
    dchk("ring_mode_state", int'(edit_state), 1);
`endif
    btns[B_MODE] = 1'b0; Alarm = 1'b0;
    @(negedge clock_1s);
`ifdef SNOOZE_EN
    press(B_MODE);
`endif
    press(B_MODE);
    btns[B_SET] = 1'b1;
    @(negedge clock_1s);
    dchk("shadow_kept_la", int'(load_alarm), 1);
    dchk("shadow_kept_digits", digits(), 701);
    btns[B_SET] = 1'b0;

    // Reset in the middle of the commit cycle
    #2 reset = 1'b1;
    #1 dchk("reset_mid_commit", all_outs(), 0);
    @(negedge clock_1s);
    reset = 1'b0;

    // Random phase
    alarm_left = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock_1s);
      if (c == 2000) begin
        #2 reset = 1'b1;
        #1 dchk("reset_random", all_outs(), 0);
        @(negedge clock_1s);
        reset = 1'b0;
      end
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 3) == 0) btns[b] = ~btns[b];
      if (alarm_left == 0) begin
        Alarm = ~Alarm;
        alarm_left = Alarm ? int'($urandom_range(1, 90)) : int'($urandom_range(1, 15));
      end
      alarm_left--;
      if ($urandom_range(0, 49) == 0) alarm_en_sw = ~alarm_en_sw;
      if ($urandom_range(0, 9) == 0) set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
    end
    @(negedge clock_1s);
    #1 dchk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
